spi_rx_ctrl: RTL and testbench

//   SPI slave receive sequencer (mode 0, MSB first) sitting between the SPI pins and an

---
 rtl/spi_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_spi_rx_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_ctrl.sv
// SPI mode-0 (MSB first) slave receive sequencer: syncs the pins, drives an external deserializer, holds words for the core.
// Optional feature macro: SPI_RX_TIMEOUT_EN (abort a stalled frame after TIMEOUT_CYCLES idle clk cycles).
`timescale 1ns/1ps

module spi_rx_ctrl #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             des_en,
  output logic             des_bit,
  input  logic [WIDTH-1:0] des_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             abort,
  output logic             busy
);

  // Handshake: rx_data is offered while rx_valid=1; the word is consumed on the clk edge
  // where rx_valid & rx_ready are both high, and rx_valid never drops without that.

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
`ifdef SPI_RX_TIMEOUT_EN
    , S_WAIT_SS = 2'd3
`endif
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   evt_q, evt_d;
  logic                   rx_bit_q, rx_bit_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   abort_q, abort_d;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  logic sclk_s, ss_s, mosi_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // The sample event is registered together with the mosi bit so both reach the
  // deserializer in the same cycle.
  assign des_en   = (state_q == S_SHIFT) && evt_q && !ss_s;
  assign des_bit  = des_en & rx_bit_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign abort    = abort_q;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    evt_d       = sclk_s && !sclk_prev_q && !ss_s;
    rx_bit_d    = mosi_s;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!ss_s) state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (ss_s) begin
          abort_d   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (evt_q) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
`ifdef SPI_RX_TIMEOUT_EN
        end else if (bit_cnt_q != '0) begin
          if (to_cnt_q == TO_LAST) begin
            abort_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_WAIT_SS;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end

      S_LOAD: begin
        // A pop on this same edge frees the register, so the new word still fits.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = des_data;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        bit_cnt_d = '0;
        state_d   = ss_s ? S_IDLE : S_SHIFT;
      end

`ifdef SPI_RX_TIMEOUT_EN
      S_WAIT_SS: begin
        if (ss_s) state_d = S_IDLE;
      end
`endif

      default: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      evt_q       <= 1'b0;
      rx_bit_q    <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      evt_q       <= evt_d;
      rx_bit_q    <= rx_bit_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
`ifdef SPI_RX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Bench for spi_rx_ctrl: directed scenarios plus randomized frames against a frame-level reference model.
`timescale 1ns/1ps

module tb_spi_rx_ctrl;

  localparam int W    = 8;
  localparam int HALF = 4;
  localparam int TO   = 64;

  logic         clk = 1'b0;
  logic         rst, sclk, ss_n, mosi, rx_ready;
  logic         des_en, des_bit, rx_valid, overrun, abort, busy;
  logic [W-1:0] des_data, rx_data;
  logic [W-1:0] des_sr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];

  int exp_abort    = 0;
  int n_abort_seen = 0;
  int n_ov_seen    = 0;
  int lat_meas     = 0;
  bit rdy_rand     = 1'b0;

  bit           m_valid = 1'b0;
  bit           m_ov = 1'b0;
  bit           load_pending = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] load_word = '0;
  int           bitcnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spi_rx_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .des_en   (des_en),
    .des_bit  (des_bit),
    .des_data (des_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .abort    (abort),
    .busy     (busy)
  );

  // External MSB-first deserializer
  assign des_data = des_sr;
  always @(posedge clk) if (des_en) des_sr <= {des_sr[W-2:0], des_bit};

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic spi_bit(input logic b, input bit measure);
    mosi = b;
    bit_q.push_back(b);
    wait_clks(HALF);
    sclk = 1'b1;
    if (measure) begin
      lat_meas = -1;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        if (rx_valid && lat_meas < 0) lat_meas = k;
      end
      #2;
    end else begin
      wait_clks(HALF);
    end
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [W-1:0] w, input int nbits, input bit end_ss, input bit measure);
    if (ss_n) begin
      ss_n = 1'b0;
      wait_clks(HALF);
    end
    if (nbits == W) exp_q.push_back(w);
    for (int i = 0; i < nbits; i++) spi_bit(w[W-1-i], measure && (i == nbits - 1));
    if (end_ss) begin
      wait_clks(HALF);
      ss_n = 1'b1;
      wait_clks(2 * HALF);
      if (nbits > 0 && nbits < W) exp_abort++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rdy_rand) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    bit           nv, nov;
    logic [W-1:0] nd;
    if (rst) begin
      check("rst_outputs", {18'd0, des_en, des_bit, rx_valid, overrun, abort, busy, rx_data}, 32'd0);
      m_valid = 1'b0; m_ov = 1'b0; load_pending = 1'b0; m_data = '0; bitcnt = 0;
      bit_q.delete();
      exp_q.delete();
    end else begin
      check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      if (m_valid) check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      check("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if (abort) n_abort_seen++;
      if (overrun) n_ov_seen++;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);

      nv  = m_valid && !rx_ready;
      nd  = m_data;
      nov = 1'b0;
      if (load_pending) begin
        if (!m_valid || rx_ready) begin
          nv = 1'b1;
          nd = load_word;
        end else begin
          nov = 1'b1;
        end
        load_pending = 1'b0;
      end
      if (ss_n) bitcnt = 0;
      if (des_en) begin
        if (bit_q.size() == 0) fail_now("des_en_unexpected");
        else check("des_bit", {31'd0, des_bit}, {31'd0, bit_q.pop_front()});
        bitcnt++;
        if (bitcnt == W) begin
          bitcnt = 0;
          if (exp_q.size() == 0) fail_now("frame_unexpected");
          else load_word = exp_q.pop_front();
          load_pending = 1'b1;
        end
      end
      m_valid = nv;
      m_data  = nd;
      m_ov    = nov;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ov_base, ab_base;
    logic [W-1:0] w;
    int nb;
    bit es;

    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    wait_clks(4);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single frame 0xA5, latency, hold until ready
    spi_frame(8'hA5, W, 1'b1, 1'b1);
    check("latency_edges", lat_meas, 32'd4);
    wait_clks(6);
    check("a5_valid_held", {31'd0, rx_valid}, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    acc_q.delete();
    rx_ready = 1'b1;
    wait_clks(1);
    check("a5_valid_dropped", {31'd0, rx_valid}, 32'd0);
    check("a5_popped", {24'd0, acc_q[0]}, 32'h0000_00A5);

    // Back-to-back frames with ss_n held low
    acc_q.delete();
    ov_base = n_ov_seen;
    spi_frame(8'h3C, W, 1'b0, 1'b0);
    spi_frame(8'hC3, W, 1'b1, 1'b0);
    wait_clks(10);
    check("b2b_count", acc_q.size(), 32'd2);
    check("b2b_word0", {24'd0, acc_q[0]}, 32'h0000_003C);
    check("b2b_word1", {24'd0, acc_q[1]}, 32'h0000_00C3);
    check("b2b_no_overrun", n_ov_seen - ov_base, 32'd0);

    // Overrun: second word dropped while holding register full
    rx_ready = 1'b0;
    acc_q.delete();
    ov_base = n_ov_seen;
    spi_frame(8'h11, W, 1'b1, 1'b0);
    spi_frame(8'h22, W, 1'b1, 1'b0);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h0000_0011);
    check("ovr_pulses", n_ov_seen - ov_base, 32'd1);
    rx_ready = 1'b1;
    wait_clks(1);
    check("ovr_valid_dropped", {31'd0, rx_valid}, 32'd0);
    wait_clks(10);
    check("ovr_only_one_pop", acc_q.size(), 32'd1);
    check("ovr_popped_word", {24'd0, acc_q[0]}, 32'h0000_0011);

    // Abort after 5 bits, then a full frame
    acc_q.delete();
    ab_base = n_abort_seen;
    spi_frame(8'hF0, 5, 1'b1, 1'b0);
    check("abort_pulses", n_abort_seen - ab_base, 32'd1);
    check("abort_no_valid", {31'd0, rx_valid}, 32'd0);
    spi_frame(8'h7E, W, 1'b1, 1'b0);
    wait_clks(6);
    check("after_abort_count", acc_q.size(), 32'd1);
    check("after_abort_word", {24'd0, acc_q[0]}, 32'h0000_007E);

    // Stalled frame: 3 bits then sclk stops with ss_n low
    ab_base = n_abort_seen;
    ss_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
    wait_clks(200);
`ifdef SPI_RX_TIMEOUT_EN
    exp_abort++;
    check("stall_abort", n_abort_seen - ab_base, 32'd1);
`else
    check("stall_no_abort", n_abort_seen - ab_base, 32'd0);
`endif
    check("stall_busy", {31'd0, busy}, 32'd1);
    ss_n = 1'b1;
    wait_clks(10);
`ifndef SPI_RX_TIMEOUT_EN
    exp_abort++;
`endif
    check("stall_abort_total", n_abort_seen, exp_abort);
    check("stall_idle_busy", {31'd0, busy}, 32'd0);

    // Async reset mid-frame with a word held
    rx_ready = 1'b0;
    spi_frame(8'h96, W, 1'b1, 1'b0);
    check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    ss_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async", {18'd0, des_en, des_bit, rx_valid, overrun, abort, busy, rx_data}, 32'd0);
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    wait_clks(2);
    rx_ready = 1'b1;
    acc_q.delete();
    spi_frame(8'h5A, W, 1'b1, 1'b0);
    wait_clks(6);
    check("post_rst_count", acc_q.size(), 32'd1);
    check("post_rst_word", {24'd0, acc_q[0]}, 32'h0000_005A);

    // Randomized frames, partial frames and consumer back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      w  = W'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W - 1)) : W;
      es = (nb != W) || (n == 19) || ($urandom_range(0, 1) == 1);
      spi_frame(w, nb, es, 1'b0);
      if (!es && $urandom_range(0, 1) == 1) wait_clks($urandom_range(0, 6));
    end
    rdy_rand = 1'b0;
    wait_clks(2);
    rx_ready = 1'b1;
    wait_clks(40);

    check("final_abort_total", n_abort_seen, exp_abort);
    check("final_bits_left", bit_q.size(), 32'd0);
    check("final_frames_left", exp_q.size(), 32'd0);
    check("final_valid", {31'd0, rx_valid}, 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
